// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier block.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    CALC,
    OUT_LO,
    OUT_HI
  } state_t;

endpackage

// File: rtl/booth_multiplier_n_if.sv
// Operand/product handshake bundle between a requester and the Booth multiplier.
interface booth_multiplier_n_if #(
  parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             sgnd;
  logic [WIDTH-1:0] inBus;
  logic [WIDTH-1:0] outBus;
  logic             done;
  logic             busy;

  modport master (
    output start, sgnd, inBus,
    input  outBus, done, busy
  );

  modport slave (
    input  start, sgnd, inBus,
    output outBus, done, busy
  );

endinterface

// File: rtl/booth_mult_ctrl.sv
// Sequencer for the Booth multiplier: state machine, iteration counter and mode latch.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   sgnd,
  output state_t state,
  output logic   mode
);

  localparam int CW = $clog2(WIDTH + 2);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   count_q;
  logic            mode_q;
  logic            last_iter;

  // Unsigned operands need one extra step to consume the zero extension bit.
  assign last_iter = (count_q == (mode_q ? CW'(WIDTH - 1) : CW'(WIDTH)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_X;
      LOAD_X:  state_d = LOAD_Y;
      LOAD_Y:  state_d = CALC;
      CALC:    if (last_iter) state_d = OUT_LO;
      OUT_LO:  state_d = OUT_HI;
      OUT_HI:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        mode_q <= sgnd;
      end
      if (state_q == LOAD_Y) begin
        count_q <= '0;
      end else if (state_q == CALC) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign state = state_q;
  assign mode  = mode_q;

endmodule

// File: rtl/booth_multiplier_n.sv
// Sequential radix-2 Booth multiplier with a shared operand bus and a two-beat product bus.
module booth_multiplier_n
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_multiplier_n_if.slave  bus
);

  state_t             state;
  logic               mode;
  logic [WIDTH:0]     a_q;
  logic [WIDTH:0]     x_q;
  logic [WIDTH:0]     y_q;
  logic               y_prev;
  logic [WIDTH:0]     in_ext;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] prod_full;
  logic [2*WIDTH-1:0] product;
  logic               unused_prod;

  booth_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .sgnd  (bus.sgnd),
    .state (state),
    .mode  (mode)
  );

  assign in_ext = {mode & bus.inBus[WIDTH-1], bus.inBus};

  always_comb begin
    sum = a_q;
    case ({y_q[0], y_prev})
      2'b01:   sum = a_q + x_q;
      2'b10:   sum = a_q - x_q;
      default: sum = a_q;
    endcase
  end

  // One Booth step per CALC cycle: add/subtract, then arithmetic shift of {A,Y,Y-1}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      y_prev <= 1'b0;
    end else begin
      case (state)
        LOAD_X: x_q <= in_ext;
        LOAD_Y: begin
          y_q    <= in_ext;
          a_q    <= '0;
          y_prev <= 1'b0;
        end
        CALC: begin
          a_q    <= {sum[WIDTH], sum[WIDTH:1]};
          y_q    <= {sum[0], y_q[WIDTH:1]};
          y_prev <= y_q[0];
        end
        default: ;
      endcase
    end
  end

  // Signed mode runs one step fewer, so its product sits one bit higher in {A,Y}.
  assign prod_full   = mode ? {a_q[WIDTH], a_q, y_q[WIDTH:1]} : {a_q, y_q};
  assign product     = prod_full[2*WIDTH-1:0];
  assign unused_prod = ^prod_full[2*WIDTH+1:2*WIDTH];

  always_comb begin
    bus.outBus = '0;
    case (state)
      OUT_LO:  bus.outBus = product[WIDTH-1:0];
      OUT_HI:  bus.outBus = product[2*WIDTH-1:WIDTH];
      default: bus.outBus = '0;
    endcase
  end

  assign bus.done = (state == OUT_LO) || (state == OUT_HI);
  assign bus.busy = (state != IDLE);

endmodule

// File: doc/booth_multiplier_n.md
BOOTH_MULTIPLIER_N -- requirements
Module: booth_multiplier_n

Interface
REQ-001 Parameter WIDTH, default 6: operand and bus width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new multiplication; sampled only in IDLE.
REQ-005 sgnd  input  1  mode, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 inBus  input  WIDTH  operand bus: X in LOAD_X, then Y in LOAD_Y.
REQ-007 outBus  output  WIDTH  product bus: low half, then high half.
REQ-008 done  output  1  high exactly while outBus carries a valid product half.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 The block SHALL implement states IDLE, LOAD_X, LOAD_Y, CALC, OUT_LO, OUT_HI.
REQ-011 Transitions SHALL be:
- IDLE->LOAD_X on start=1, latching sgnd into mode register M.
- LOAD_X->LOAD_Y unconditionally.
- LOAD_Y->CALC unconditionally.
- CALC->OUT_LO when the iteration counter reaches I-1.
- OUT_LO->OUT_HI, then OUT_HI->IDLE.
REQ-012 In LOAD_X, X SHALL capture inBus, extended to WIDTH+1 bits: sign-extended if M=1, zero-extended if M=0.
REQ-013 LOAD_Y SHALL capture inBus into Y, extended as in REQ-012, and clear A (WIDTH+1 bits), Y-1 and the counter.
REQ-014 Iteration count I SHALL be WIDTH when M=1 and WIDTH+1 when M=0.
REQ-015 Each CALC cycle SHALL perform the radix-2 Booth step, then arithmetic-shift {A,Y,Y-1} right by one, in one clock:
- {Y0,Y-1}=01: A+=X.
- {Y0,Y-1}=10: A-=X.
- {Y0,Y-1}=00 or 11: no add.
REQ-016 All arithmetic SHALL be modulo 2^(WIDTH+1); the product is the low 2*WIDTH bits of {A,Y}.
REQ-017 outBus SHALL be:
- product[WIDTH-1:0] in OUT_LO.
- product[2*WIDTH-1:WIDTH] in OUT_HI.
- zero in all other states.
REQ-018 done SHALL be 1 in OUT_LO and OUT_HI only.
REQ-019 Latency: start sampled at edge 0 gives OUT_LO in cycle I+3 and OUT_HI in cycle I+4; the block is back in IDLE at cycle I+5.
REQ-020 start, and changes on sgnd, SHALL be ignored outside IDLE; no queuing.
REQ-021 start held high through OUT_HI SHALL begin a new operation on the first IDLE cycle.
REQ-022 Operand -2^(WIDTH-1) with M=1 SHALL produce the correct result; the WIDTH+1 internal width prevents overflow.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE and clear A, X, Y, Y-1, M and the counter.
REQ-024 During and after reset, outBus=0, done=0 and busy=0.
REQ-025 Reset during any non-IDLE state SHALL abort the operation; no partial result SHALL appear.

Structure
REQ-026 Package booth_pkg SHALL hold the state enumeration and the default WIDTH constant.
REQ-027 The FSM and counter SHALL be sub-module booth_mult_ctrl, with the datapath in the top module.
REQ-028 Counter width SHALL be clog2(WIDTH+2).

Verification
REQ-029 WIDTH=6, sgnd=1, X=5, Y=-3 (0x3D) -> done 2 cycles; outBus 0x31 then 0x3F (-15); OUT_LO at cycle 9.
REQ-030 WIDTH=6, sgnd=0, X=63, Y=63 -> outBus 0x01 then 0x3E (3969); OUT_LO at cycle 10.
REQ-031 WIDTH=6, sgnd=1, X=-32, Y=-32 -> outBus 0x00 then 0x10 (1024).
REQ-032 start pulsed and sgnd toggled during CALC -> result and timing unchanged; one done pair only.
REQ-033 rst asserted in the 3rd CALC cycle -> outBus, done and busy go to 0 immediately; a following start with X=0, Y=17 yields 0x00, 0x00.
REQ-034 WIDTH=8, random signed/unsigned pairs -> product matches reference model; I+5 cycles per operation.
